// File: rtl/mac_lane_feeder.sv
// Job sequencer for mac_lane: optional bias beat, then per pass one weight vector
// and rows_m1+1 framed IFM rows, with elements encoded as {is_zero, value}.

module mac_lane_feeder_enc #(
   parameter int ELEM_W = 9
) (
   input  logic [ELEM_W-1:0] elem,
   output logic [ELEM_W:0]   enc
);
   assign enc = {elem == '0, elem};
endmodule

module mac_lane_feeder #(
   parameter int LANES  = 64,
   parameter int ELEM_W = 9
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic                         i_cmd_valid,
   output logic                         o_cmd_ready,
   input  logic [31:0]                  i_cmd_bias,
   input  logic                         i_cmd_bias_en,
   input  logic [5:0]                   i_cmd_rows_m1,
   input  logic [1:0]                   i_cmd_accum_m1,
   input  logic                         i_w_valid,
   output logic                         o_w_ready,
   input  logic [LANES*ELEM_W-1:0]      i_w_data,
   input  logic                         i_row_valid,
   output logic                         o_row_ready,
   input  logic [LANES*ELEM_W-1:0]      i_row_data,
   input  logic [LANES-1:0]             i_row_mask,
   output logic                         o_bias_valid,
   input  logic                         i_bias_ready,
   output logic [31:0]                  o_bias,
   output logic                         o_wfm_valid,
   output logic [LANES*(ELEM_W+1)-1:0]  o_wfm_data,
   output logic                         o_ifm_valid,
   input  logic                         i_ifm_ready,
   output logic [LANES*(ELEM_W+1)-1:0]  o_ifm_data,
   output logic [LANES-1:0]             o_ifm_elem_valid,
   output logic                         o_ifm_inter_end,
   output logic                         o_ifm_accum_end,
   output logic                         o_busy,
   output logic                         o_done
);
   localparam int XW = ELEM_W + 1;

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] BIAS = 3'd1;
   localparam logic [2:0] WFM  = 3'd2;
   localparam logic [2:0] IFM  = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   logic [2:0]             state;
   logic [31:0]            bias_q;
   logic [5:0]             rows_m1;
   logic [1:0]             accum_m1;
   logic [6:0]             row_cnt;
   logic [1:0]             pass_cnt;
   logic                   wfm_valid;
   logic [LANES*XW-1:0]    wfm_q;
   logic                   ifm_valid;
   logic [LANES*XW-1:0]    ifm_q;
   logic [LANES-1:0]       mask_q;
   logic                   inter_end;
   logic                   accum_end;

   logic [LANES-1:0][XW-1:0] w_enc;
   logic [LANES-1:0][XW-1:0] row_enc;

   logic row_hs, w_hs, drain, last_acc, fetch_ok;

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      mac_lane_feeder_enc #(.ELEM_W(ELEM_W)) u_w_enc (
         .elem (i_w_data[k*ELEM_W +: ELEM_W]),
         .enc  (w_enc[k])
      );
      mac_lane_feeder_enc #(.ELEM_W(ELEM_W)) u_row_enc (
         .elem (i_row_data[k*ELEM_W +: ELEM_W]),
         .enc  (row_enc[k])
      );
   end

   // row_cnt runs to rows_m1+1, which stops fetching once the last row is loaded
   assign fetch_ok    = row_cnt <= {1'b0, rows_m1};
   assign o_row_ready = (state == IFM) & fetch_ok & (~ifm_valid | i_ifm_ready);
   assign o_w_ready   = (state == WFM);
   assign o_cmd_ready = (state == IDLE);
   assign o_bias_valid = (state == BIAS);
   assign o_busy      = (state != IDLE);
   assign o_done      = (state == DONE);

   assign row_hs   = i_row_valid & o_row_ready;
   assign w_hs     = i_w_valid & o_w_ready;
   assign drain    = ifm_valid & i_ifm_ready;
   assign last_acc = drain & inter_end;

   assign o_bias           = bias_q;
   assign o_wfm_valid      = wfm_valid;
   assign o_wfm_data       = wfm_q;
   assign o_ifm_valid      = ifm_valid;
   assign o_ifm_data       = ifm_q;
   assign o_ifm_elem_valid = mask_q;
   assign o_ifm_inter_end  = inter_end;
   assign o_ifm_accum_end  = accum_end;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state     <= IDLE;
         bias_q    <= '0;
         rows_m1   <= '0;
         accum_m1  <= '0;
         row_cnt   <= '0;
         pass_cnt  <= '0;
         wfm_valid <= 1'b0;
         wfm_q     <= '0;
         ifm_valid <= 1'b0;
         ifm_q     <= '0;
         mask_q    <= '0;
         inter_end <= 1'b0;
         accum_end <= 1'b0;
      end else begin
         // single output stage: load and drain may happen in the same cycle
         if (row_hs) begin
            ifm_valid <= 1'b1;
            ifm_q     <= row_enc;
            mask_q    <= i_row_mask;
            inter_end <= (row_cnt == {1'b0, rows_m1});
            accum_end <= (pass_cnt == accum_m1);
            row_cnt   <= row_cnt + 7'd1;
         end else if (drain) begin
            ifm_valid <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (i_cmd_valid) begin
                  bias_q   <= i_cmd_bias;
                  rows_m1  <= i_cmd_rows_m1;
                  accum_m1 <= i_cmd_accum_m1;
                  row_cnt  <= '0;
                  pass_cnt <= '0;
                  state    <= i_cmd_bias_en ? BIAS : WFM;
               end
            end
            BIAS: begin
               if (i_bias_ready) state <= WFM;
            end
            WFM: begin
               if (w_hs) begin
                  wfm_q     <= w_enc;
                  wfm_valid <= 1'b1;
                  state     <= IFM;
               end
            end
            IFM: begin
               if (last_acc) begin
                  wfm_valid <= 1'b0;
                  row_cnt   <= '0;
                  if (accum_end) begin
                     state <= DONE;
                  end else begin
                     pass_cnt <= pass_cnt + 2'd1;
                     state    <= WFM;
                  end
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
